obi_ahb_bridge: RTL and testbench
=================================

OBI_AHB_BRIDGE -- requirements
Module: obi_ahb_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: width of every address port; legal values 32..64.
REQ-002 Parameter ARB_MODE, default 0: 0 = fixed priority, data before instr; 1 = round-robin between instr and data.
REQ-003 Parameter TIMEOUT, default 0: maximum data-phase wait-state cycles before a local error; 0 disables the timeout.
REQ-004 HCLK  in  1  clock; all state updates on its rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 instr_req_i  in  1  instruction fetch request.
REQ-007 instr_addr_i  in  ADDR_W  fetch address; bits [1:0] are ignored.
REQ-008 instr_gnt_o / instr_rvalid_o / instr_err_o  out  1 each  grant, response valid, response error.
REQ-009 instr_rdata_o  out  32  fetch data.
REQ-010 data_req_i / data_we_i  in  1 each  data request, write enable.
REQ-011 data_be_i  in  4  byte enables.
REQ-012 data_addr_i  in  ADDR_W  data address; bits [1:0] are ignored.
REQ-013 data_wdata_i  in  32  write data.
REQ-014 data_gnt_o / data_rvalid_o / data_err_o  out  1 each  grant, response valid, response error.
REQ-015 data_rdata_o  out  32  load data.
REQ-016 HADDR  out  ADDR_W;  HSIZE  out  3;  HTRANS  out  2;  HWRITE  out  1;  HWDATA  out  32.
REQ-017 HRDATA  in  32;  HREADY  in  1;  HRESP  in  1 (0 = OKAY, 1 = ERROR).

Function
REQ-018 The FSM SHALL have the states IDLE, ADDR, DATA and LERR, with exactly one transfer outstanding at any time.
REQ-019 In IDLE with at least one request, the bridge SHALL arbitrate per ARB_MODE and latch the winner's address, write flag, byte enables and source.
- ARB_MODE=1: the last-granted source register SHALL flip on every grant; the non-last source wins a tie.
REQ-020 If the winner is data with an illegal data_be_i, the bridge SHALL go IDLE->LERR, assert data_gnt_o in that IDLE cycle, and issue no bus transfer.
- Legal values: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-021 In LERR the bridge SHALL pulse data_rvalid_o=1 and data_err_o=1 for one cycle, then return to IDLE.
REQ-022 In ADDR the bridge SHALL drive HTRANS=NONSEQ(10), HADDR, HSIZE and HWRITE from the latched values.
- It SHALL move to DATA and pulse the winner's gnt_o in the cycle HREADY=1.
- It SHALL otherwise hold all values unchanged.
REQ-023 Instruction transfers SHALL use HSIZE=010 and HADDR = {addr[ADDR_W-1:2], 2'b00}.
REQ-024 Data transfers SHALL use the byte-enable mapping 0001/0010/0100/1000 -> HSIZE 000, offset 0/1/2/3.
- 0011 -> HSIZE 001, offset 0; 1100 -> HSIZE 001, offset 2; 1111 -> HSIZE 010, offset 0.
- HADDR = {addr[ADDR_W-1:2], offset}.
REQ-025 HWDATA SHALL be registered from data_wdata_i at address-phase acceptance and held stable throughout DATA.
REQ-026 In DATA, HTRANS SHALL be IDLE(00) and HADDR, HSIZE, HWRITE SHALL be 0.
REQ-027 In DATA with HREADY=1, the bridge SHALL pulse the owner's rvalid_o for one cycle, drive its err_o = HRESP, and return to IDLE.
- Both rdata outputs SHALL be combinational copies of HRDATA.
REQ-028 HRESP=1 with HREADY=0 (first error cycle) SHALL keep the bridge in DATA with no new transfer issued.
REQ-029 With TIMEOUT>0, a wait counter SHALL clear on DATA entry and increment on every HREADY=0 cycle.
- Reaching TIMEOUT SHALL produce rvalid_o=1, err_o=1 and a return to IDLE.
- A late HREADY for that transfer SHALL be ignored.
REQ-030 At most one gnt_o and at most one rvalid_o SHALL be high in any cycle, and never for a non-owning source.
REQ-031 A request arriving while the bridge is busy SHALL wait; its first possible grant is the IDLE cycle after the current response.
REQ-032 Address, write flag and byte enables SHALL be sampled only in IDLE; input changes at other times SHALL have no effect.

Reset
REQ-033 Asserting HRESETn=0, including mid-transfer, SHALL immediately force IDLE.
- All outputs SHALL go to 0 (HTRANS=00); the counter, the round-robin register and HWDATA SHALL clear.
- No pending rvalid SHALL be emitted.
REQ-034 After HRESETn deasserts, the first grant SHALL occur no earlier than the second rising edge of HCLK.

Verification
REQ-035 Instr fetch at 0x0000_0103, HREADY=1 always -> HADDR=0x0000_0100, HSIZE=010, instr_gnt_o at the ADDR edge, instr_rvalid_o one cycle later with rdata=HRDATA.
REQ-036 Data store, be=1100, addr 0x2000_0000, wdata 0xAABB_0000, HREADY low for 3 data cycles -> HADDR=0x2000_0002, HSIZE=001, HWRITE=1, HWDATA held 4 cycles, then data_rvalid_o with err=0.
REQ-037 Simultaneous instr and data requests for 4 rounds -> ARB_MODE=0 grants D,D,D,D; ARB_MODE=1 grants D,I,D,I.
REQ-038 Data load, be=0101 -> no HTRANS=NONSEQ; data_gnt_o, then data_rvalid_o=1 and data_err_o=1 next cycle.
REQ-039 Two-cycle HRESP error (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) -> single rvalid with err=1; TIMEOUT=4 with HREADY stuck low -> err response after 4 wait cycles.
REQ-040 HRESETn pulsed low during DATA -> all outputs 0 within the reset cycle, no rvalid; the next request completes normally.

Source files
------------

// File: rtl/obi_ahb_bridge.sv
// rtl/obi_ahb_bridge.sv - OBI instruction/data ports bridged onto one AHB-Lite master
module obi_ahb_bridge #(
  parameter int ADDR_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic              instr_err_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic              data_err_o,
  output logic [31:0]       data_rdata_o,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_LERR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic              src_q;
  logic              last_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [2:0]        hsize_q;
  logic              hwrite_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       hwdata_q;
  logic              any_req;
  logic              pick_data;
  logic              be_ok;
  logic [2:0]        be_size;
  logic [1:0]        be_off;
  logic              arb_fire;
  logic              accept;
  logic              timed_out;
  logic              rsp_err;
  logic              unused_addr_lsb;

  // Address bits [1:0] of both ports carry no information; the bridge rebuilds them
  assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  assign any_req   = instr_req_i | data_req_i;
  assign arb_fire  = (state == S_IDLE) && armed && any_req;
  assign accept    = (state == S_ADDR) && HREADY;
  assign timed_out = (TIMEOUT > 0) && (wait_cnt == CNT_MAX);

  // Read data is a straight copy of the bus, silenced only while reset is held
  assign instr_rdata_o = HRESETn ? HRDATA : 32'h0;
  assign data_rdata_o  = HRESETn ? HRDATA : 32'h0;
  assign HWDATA        = hwdata_q;

  // Choose the source to serve: data first, or the one not granted last on a tie
  always_comb begin
    pick_data = data_req_i;
    if (data_req_i && instr_req_i) begin
      pick_data = (ARB_MODE == 1) ? !last_q : 1'b1;
    end
  end

  // Byte-enable pattern to transfer size and low address bits
  always_comb begin
    be_ok   = 1'b1;
    be_size = 3'b000;
    be_off  = 2'b00;
    case (data_be_i)
      4'b0001: begin be_size = 3'b000; be_off = 2'd0; end
      4'b0010: begin be_size = 3'b000; be_off = 2'd1; end
      4'b0100: begin be_size = 3'b000; be_off = 2'd2; end
      4'b1000: begin be_size = 3'b000; be_off = 2'd3; end
      4'b0011: begin be_size = 3'b001; be_off = 2'd0; end
      4'b1100: begin be_size = 3'b001; be_off = 2'd2; end
      4'b1111: begin be_size = 3'b010; be_off = 2'd0; end
      default: be_ok = 1'b0;
    endcase
  end

  // Next state, grants, responses and AHB address-phase drive
  always_comb begin
    state_nxt      = state;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    HTRANS         = 2'b00;
    HADDR          = '0;
    HSIZE          = 3'b000;
    HWRITE         = 1'b0;
    rsp_err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_fire) begin
          if (pick_data && !be_ok) begin
            state_nxt  = S_LERR;
            data_gnt_o = 1'b1;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        HTRANS = 2'b10;
        HADDR  = haddr_q;
        HSIZE  = hsize_q;
        HWRITE = hwrite_q;
        if (HREADY) begin
          state_nxt   = S_DATA;
          instr_gnt_o = !src_q;
          data_gnt_o  = src_q;
        end
      end
      S_DATA: begin
        if (timed_out || HREADY) begin
          state_nxt      = S_IDLE;
          rsp_err        = timed_out | HRESP;
          instr_rvalid_o = !src_q;
          instr_err_o    = !src_q & rsp_err;
          data_rvalid_o  = src_q;
          data_err_o     = src_q & rsp_err;
        end
      end
      S_LERR: begin
        state_nxt     = S_IDLE;
        data_rvalid_o = 1'b1;
        data_err_o    = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Hold off arbitration for the first edge after reset release
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  // Capture the winner's transfer attributes when arbitration fires
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src_q    <= 1'b0;
      haddr_q  <= '0;
      hsize_q  <= 3'b000;
      hwrite_q <= 1'b0;
    end else if (arb_fire) begin
      src_q <= pick_data;
      if (pick_data) begin
        haddr_q  <= {data_addr_i[ADDR_W-1:2], be_off};
        hsize_q  <= be_size;
        hwrite_q <= data_we_i;
      end else begin
        haddr_q  <= {instr_addr_i[ADDR_W-1:2], 2'b00};
        hsize_q  <= 3'b010;
        hwrite_q <= 1'b0;
      end
    end
  end

  // Round-robin memory toggles on every grant pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                       last_q <= 1'b0;
    else if (instr_gnt_o || data_gnt_o) last_q <= !last_q;
  end

  // Write data is taken when the address phase is accepted and held through DATA
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)              hwdata_q <= 32'h0;
    else if (accept && src_q)  hwdata_q <= data_wdata_i;
  end

  // Data-phase wait-state counter for the local timeout
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == S_DATA) && !HREADY && !timed_out) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_ahb_bridge.sv
// tb/tb_obi_ahb_bridge.sv - randomized bridge checks against a transaction-level model
module tb_obi_ahb_bridge;
  localparam int AW   = 32;
  localparam int TO_A = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          instr_req, data_req, data_we, HREADY, HRESP;
  logic [AW-1:0] instr_addr, data_addr;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata, HRDATA;

  wire          a_ig, a_irv, a_ie, a_dg, a_drv, a_de, a_hw;
  wire [31:0]   a_ird, a_drd, a_hwd;
  wire [AW-1:0] a_ha;
  wire [2:0]    a_hs;
  wire [1:0]    a_ht;
  wire          b_ig, b_irv, b_ie, b_dg, b_drv, b_de, b_hw;
  wire [31:0]   b_ird, b_drd, b_hwd;
  wire [AW-1:0] b_ha;
  wire [2:0]    b_hs;
  wire [1:0]    b_ht;

  logic          o_ig, o_irv, o_ie, o_dg, o_drv, o_de, o_hw;
  logic [31:0]   o_ird, o_drd, o_hwd;
  logic [AW-1:0] o_ha;
  logic [2:0]    o_hs;
  logic [1:0]    o_ht;
  logic          sel;

  always #5 HCLK = ~HCLK;

  obi_ahb_bridge #(.ADDR_W(AW), .ARB_MODE(1), .TIMEOUT(TO_A)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(a_ig), .instr_rvalid_o(a_irv), .instr_err_o(a_ie), .instr_rdata_o(a_ird),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(a_dg), .data_rvalid_o(a_drv), .data_err_o(a_de), .data_rdata_o(a_drd),
    .HADDR(a_ha), .HSIZE(a_hs), .HTRANS(a_ht), .HWRITE(a_hw), .HWDATA(a_hwd),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  obi_ahb_bridge #(.ADDR_W(AW), .ARB_MODE(0), .TIMEOUT(0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(b_ig), .instr_rvalid_o(b_irv), .instr_err_o(b_ie), .instr_rdata_o(b_ird),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(b_dg), .data_rvalid_o(b_drv), .data_err_o(b_de), .data_rdata_o(b_drd),
    .HADDR(b_ha), .HSIZE(b_hs), .HTRANS(b_ht), .HWRITE(b_hw), .HWDATA(b_hwd),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // View whichever bridge is under test
  always_comb begin
    if (sel) begin
      o_ig = b_ig; o_irv = b_irv; o_ie = b_ie; o_ird = b_ird;
      o_dg = b_dg; o_drv = b_drv; o_de = b_de; o_drd = b_drd;
      o_ha = b_ha; o_hs = b_hs; o_ht = b_ht; o_hw = b_hw; o_hwd = b_hwd;
    end else begin
      o_ig = a_ig; o_irv = a_irv; o_ie = a_ie; o_ird = a_ird;
      o_dg = a_dg; o_drv = a_drv; o_de = a_de; o_drd = a_drd;
      o_ha = a_ha; o_hs = a_hs; o_ht = a_ht; o_hw = a_hw; o_hwd = a_hwd;
    end
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit            m_arb;
  int            m_to;
  bit            last_data;
  logic [31:0]   exp_hwdata;
  bit            pend_i, pend_d;
  logic [AW-1:0] ia, da;
  logic [3:0]    dbe;
  bit            dwe;
  logic [31:0]   dwd;
  logic [3:0]    legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int low_idx(input logic [3:0] v);
    int idx = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) idx = i;
    return idx;
  endfunction

  // Legal enables: 1, 2 or 4 contiguous lanes naturally aligned to their size
  function automatic bit be_legal(input logic [3:0] v);
    int n   = popc(v);
    int off = low_idx(v);
    logic [3:0] shape;
    if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
    if (off % n != 0) return 1'b0;
    shape = 4'(((1 << n) - 1) << off);
    return v == shape;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_igt"}, o_ig, 0);
    check_eq({tag, "_irv"}, o_irv, 0);
    check_eq({tag, "_ierr"}, o_ie, 0);
    check_eq({tag, "_ird"}, o_ird, 0);
    check_eq({tag, "_dgt"}, o_dg, 0);
    check_eq({tag, "_drv"}, o_drv, 0);
    check_eq({tag, "_derr"}, o_de, 0);
    check_eq({tag, "_drd"}, o_drd, 0);
    check_eq({tag, "_haddr"}, o_ha, 0);
    check_eq({tag, "_hsize"}, o_hs, 0);
    check_eq({tag, "_htrans"}, o_ht, 0);
    check_eq({tag, "_hwrite"}, o_hw, 0);
    check_eq({tag, "_hwdata"}, o_hwd, 0);
  endtask

  task automatic check_bus_idle(input string tag);
    check_eq({tag, "_htrans"}, o_ht, 0);
    check_eq({tag, "_haddr"}, o_ha, 0);
    check_eq({tag, "_hsize"}, o_hs, 0);
    check_eq({tag, "_hwrite"}, o_hw, 0);
    check_eq({tag, "_hwdata"}, o_hwd, exp_hwdata);
  endtask

  task automatic reset_seq();
    @(negedge HCLK);
    HRESETn   = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    HRDATA    = 32'hDEAD_BEEF;
    HREADY    = 1'b1;
    pend_i = 0; pend_d = 0; last_data = 0; exp_hwdata = 32'h0;
    #1;
    check_outputs_zero("rst");
    @(negedge HCLK);
    HRESETn  = 1'b1;
    data_req = 1'b1;
    data_be  = 4'b0101;
    #1;
    check_eq("rst_first_gnt", o_dg, 0);
    data_req = 1'b0;
  endtask

  // One arbitration round through to the response; abort pulls reset in the data phase
  task automatic do_round(input bit abort);
    bit            win_d, illegal, done, timeout, exp_err;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_size;
    bit            exp_we, err_pl;
    int            aw, dw, n;

    if (!pend_i && $urandom_range(0, 2) != 0) begin
      pend_i = 1; ia = $urandom;
    end
    if (!pend_d && ($urandom_range(0, 2) != 0 || !pend_i)) begin
      pend_d = 1; da = $urandom; dwe = 1'($urandom); dwd = $urandom;
      dbe = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_be[$urandom_range(0, 6)];
    end

    @(negedge HCLK);
    instr_req = pend_i; instr_addr = ia;
    data_req = pend_d; data_addr = da; data_be = dbe; data_we = dwe; data_wdata = dwd;
    HREADY = 1'($urandom); HRESP = 1'b0;
    if (pend_i && pend_d) win_d = m_arb ? !last_data : 1'b1;
    else                  win_d = pend_d;
    illegal = win_d && !be_legal(dbe);
    #1;
    check_eq("idle_igt", o_ig, 0);
    check_eq("idle_dgt", o_dg, illegal);
    check_eq("idle_irv", o_irv, 0);
    check_eq("idle_drv", o_drv, 0);
    check_bus_idle("idle");

    last_data = !last_data;
    if (win_d) pend_d = 0; else pend_i = 0;

    if (illegal) begin
      @(negedge HCLK);
      instr_req = pend_i; data_req = pend_d;
      #1;
      check_eq("lerr_drv", o_drv, 1);
      check_eq("lerr_derr", o_de, 1);
      check_eq("lerr_irv", o_irv, 0);
      check_eq("lerr_gnt", {o_ig, o_dg}, 0);
      check_bus_idle("lerr");
      return;
    end

    n        = popc(dbe);
    exp_addr = win_d ? {da[AW-1:2], 2'(low_idx(dbe))} : {ia[AW-1:2], 2'b00};
    exp_size = !win_d ? 3'd2 : (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    exp_we   = win_d && dwe;
    aw       = $urandom_range(0, 2);
    for (int k = 0; k <= aw; k++) begin
      @(negedge HCLK);
      if (win_d) begin
        data_addr = $urandom; data_be = 4'($urandom); data_we = 1'($urandom);
      end else begin
        instr_addr = $urandom;
      end
      HREADY = (k == aw); HRESP = 1'b0;
      #1;
      check_eq("addr_htrans", o_ht, 2'b10);
      check_eq("addr_haddr", o_ha, exp_addr);
      check_eq("addr_hsize", o_hs, exp_size);
      check_eq("addr_hwrite", o_hw, exp_we);
      check_eq("addr_hwdata", o_hwd, exp_hwdata);
      check_eq("addr_igt", o_ig, !win_d && k == aw);
      check_eq("addr_dgt", o_dg, win_d && k == aw);
      check_eq("addr_rv", {o_irv, o_drv}, 0);
    end
    if (win_d) exp_hwdata = dwd;

    dw     = $urandom_range(0, 6);
    err_pl = ($urandom_range(0, 3) == 0);
    for (int j = 0; j < 16; j++) begin
      @(negedge HCLK);
      if (j == 0) begin
        instr_req = pend_i; data_req = pend_d;
        if (win_d) data_wdata = $urandom;
      end
      HRDATA  = $urandom;
      timeout = (m_to > 0) && (j == m_to);
      if (timeout) begin
        HREADY = 1'($urandom); HRESP = 1'($urandom);
      end else begin
        HREADY = (j == dw);
        HRESP  = err_pl && (j == dw || j == dw - 1);
      end
      if (abort) begin
        HRESETn = 1'b0; HREADY = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        return;
      end
      #1;
      done    = timeout || (j == dw);
      exp_err = timeout ? 1'b1 : err_pl;
      check_bus_idle("data");
      check_eq("data_gnt", {o_ig, o_dg}, 0);
      check_eq("data_irv", o_irv, done && !win_d);
      check_eq("data_drv", o_drv, done && win_d);
      check_eq("data_ierr", o_ie, done && !win_d && exp_err);
      check_eq("data_derr", o_de, done && win_d && exp_err);
      check_eq("data_ird", o_ird, HRDATA);
      check_eq("data_drd", o_drd, HRDATA);
      if (done) return;
    end
    check_eq("data_no_response", 0, 1);
  endtask

  initial begin
    HRESETn = 1'b0; instr_req = 0; data_req = 0; data_we = 0; data_be = 0;
    instr_addr = '0; data_addr = '0; data_wdata = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    sel = 1'b0; m_arb = 1'b1; m_to = TO_A;
    reset_seq();
    repeat (80) do_round(1'b0);

    pend_d = 1; da = 32'h2000_0000; dbe = 4'b1100; dwe = 1; dwd = 32'hAABB_0000;
    do_round(1'b1);
    reset_seq();
    repeat (40) do_round(1'b0);

    sel = 1'b1; m_arb = 1'b0; m_to = 0;
    reset_seq();
    repeat (80) do_round(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
